test_sequencer: RTL and testbench

Sequential test-harness controller that runs up to `NUM_TESTS` unit-test harnesses one after another over the `startTests` / `testDone` / `dutPassed` handshake. It drives `startTests` to each harness in turn and collects the `testDone` and `dutPassed` results. Each verdict is latched into per-test pass and timeout masks, and one summary result is raised at the end. It sits at the top of the Lab 3 CPU verification bench, above the mux, register-file, ALU and memory harnesses.

---
 rtl/test_sequencer_if.sv | 28 ++
 rtl/test_sequencer.sv | 157 +++++++++++++++
 tb/tb_test_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/test_sequencer_if.sv
// -----------------------------------------------------------------------------
// test_sequencer_if
// Handshake bundle between the test sequencer and its unit-test harnesses.
//   startTests : per-harness start level, driven by the sequencer
//   testDone   : per-harness done level, driven by the harnesses
//   dutPassed  : per-harness verdict, driven by the harnesses
// The sequencer uses the master modport and the harness side uses the slave
// modport.
// -----------------------------------------------------------------------------
interface test_sequencer_if #(
   parameter int NUM_TESTS = 4
);
   logic [NUM_TESTS-1:0] startTests;
   logic [NUM_TESTS-1:0] testDone;
   logic [NUM_TESTS-1:0] dutPassed;

   modport master (
      output startTests,
      input  testDone,
      input  dutPassed
   );

   modport slave (
      input  startTests,
      output testDone,
      output dutPassed
   );
endinterface

// File: rtl/test_sequencer.sv
// -----------------------------------------------------------------------------
// test_sequencer
// Runs NUM_TESTS unit-test harnesses one after another. For each harness it
// raises startTests[i] and waits for a rising edge on testDone[i] or for
// TIMEOUT cycles. It then records the verdict in passMask and timeoutMask, and
// finally pulses done with the AND of all verdicts on allPassed.
//
// Ports
//   clk, reset  : clock; synchronous active-high reset
//   start       : begin a run (only honoured while idle)
//   hs          : harness handshake (startTests out; testDone/dutPassed in)
//   busy        : run in progress
//   done        : one-cycle end-of-run pulse
//   allPassed   : AND of passMask, valid from done until the next run
//   passMask    : per-harness pass flags
//   timeoutMask : per-harness timeout flags
//   currentTest : index of the harness being run
// All outputs are registered.
// -----------------------------------------------------------------------------
module test_sequencer #(
   parameter int NUM_TESTS = 4,
   parameter int TIMEOUT   = 1000,
   localparam int CW       = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
   localparam int CNT_W    = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   test_sequencer_if.master     hs,
   output logic                 busy,
   output logic                 done,
   output logic                 allPassed,
   output logic [NUM_TESTS-1:0] passMask,
   output logic [NUM_TESTS-1:0] timeoutMask,
   output logic [CW-1:0]        currentTest
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RECORD,
      S_FINISH
   } state_t;

   state_t               state_q;
   logic [NUM_TESTS-1:0] startTests_q;
   logic [NUM_TESTS-1:0] prevDone_q;
   logic [NUM_TESTS-1:0] passMask_q;
   logic [NUM_TESTS-1:0] timeoutMask_q;
   logic [CW-1:0]        cur_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 allPassed_q;

   logic                 complete_d;
   logic                 timeout_d;
   logic [CNT_W-1:0]     cnt_d;

   // A harness completes only on a fresh rising edge of its done level; a
   // level already high at LAUNCH never counts and ends in a timeout.
   always_comb begin
      complete_d = hs.testDone[cur_q] & ~prevDone_q[cur_q];
      timeout_d  = (cnt_q == CNT_W'(TIMEOUT - 1));
      cnt_d      = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      // Edge-detect history is refreshed every cycle, so the copy taken in
      // LAUNCH is the reference for the first WAIT cycle.
      prevDone_q <= hs.testDone;

      if (reset) begin
         state_q       <= S_IDLE;
         startTests_q  <= '0;
         passMask_q    <= '0;
         timeoutMask_q <= '0;
         cur_q         <= '0;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         allPassed_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q       <= S_LAUNCH;
                  busy_q        <= 1'b1;
                  passMask_q    <= '0;
                  timeoutMask_q <= '0;
                  allPassed_q   <= 1'b0;
                  cur_q         <= '0;
                  cnt_q         <= '0;
               end
            end

            // startTests is low for this whole cycle so the harness always
            // sees a new rising edge when WAIT begins.
            S_LAUNCH: begin
               state_q      <= S_WAIT;
               startTests_q <= NUM_TESTS'(1) << cur_q;
            end

            // Completion is checked before timeout so a done edge arriving
            // on the final allowed cycle still counts as a verdict.
            S_WAIT: begin
               cnt_q <= cnt_d;
               if (complete_d) begin
                  passMask_q[cur_q] <= hs.dutPassed[cur_q];
                  startTests_q      <= '0;
                  state_q           <= S_RECORD;
               end else if (timeout_d) begin
                  timeoutMask_q[cur_q] <= 1'b1;
                  startTests_q         <= '0;
                  state_q              <= S_RECORD;
               end
            end

            S_RECORD: begin
               cnt_q <= '0;
               if (cur_q == CW'(NUM_TESTS - 1)) begin
                  state_q     <= S_FINISH;
                  done_q      <= 1'b1;
                  allPassed_q <= &passMask_q;
               end else begin
                  cur_q   <= cur_q + CW'(1);
                  state_q <= S_LAUNCH;
               end
            end

            S_FINISH: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               state_q      <= S_IDLE;
               startTests_q <= '0;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
            end
         endcase
      end
   end

   assign hs.startTests = startTests_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign allPassed     = allPassed_q;
   assign passMask      = passMask_q;
   assign timeoutMask   = timeoutMask_q;
   assign currentTest   = cur_q;

endmodule

// File: tb/tb_test_sequencer.sv
module tb_test_sequencer;

   localparam int NT    = 4;
   localparam int TB_TO = 8;

   logic          clk;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic          allPassed;
   logic [NT-1:0] passMask;
   logic [NT-1:0] timeoutMask;
   logic [1:0]    currentTest;

   test_sequencer_if #(.NUM_TESTS(NT)) hs ();

   test_sequencer #(.NUM_TESTS(NT), .TIMEOUT(TB_TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .hs          (hs),
      .busy        (busy),
      .done        (done),
      .allPassed   (allPassed),
      .passMask    (passMask),
      .timeoutMask (timeoutMask),
      .currentTest (currentTest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Harness behaviour for one run, plus the results the run must produce.
   typedef struct {
      string          name;
      logic [3:0][3:0] lat;      // cycles of startTests high before testDone rises
      logic [NT-1:0]  verdict;
      logic [NT-1:0]  never_m;   // harness never raises testDone
      logic [NT-1:0]  stale_m;   // testDone held high from before start
      logic           glitch;    // pulse start while harness 1 is in WAIT
      logic [NT-1:0]  exp_pass;
      logic [NT-1:0]  exp_to;
      logic           exp_all;
      int             exp_cyc;   // cycle (start cycle = 0) in which done is high
   } vec_t;

   vec_t vecs[6];
   vec_t sb_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0][3:0] cfg_lat   = 16'h5555;
   logic [NT-1:0]   cfg_never = '0;
   logic [NT-1:0]   cfg_stale = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input logic [15:0] lat,
                               input logic [3:0] vd, input logic [3:0] nv,
                               input logic [3:0] st, input logic gl,
                               input logic [3:0] ep, input logic [3:0] et,
                               input logic ea, input int ec);
      vec_t v;
      v.name = nm; v.lat = lat; v.verdict = vd; v.never_m = nv; v.stale_m = st;
      v.glitch = gl; v.exp_pass = ep; v.exp_to = et; v.exp_all = ea; v.exp_cyc = ec;
      return v;
   endfunction

   // Cycles startTests[i] should stay high: the harness answers one cycle
   // after its latency elapses, capped by the timeout.
   function automatic int exp_len(input vec_t v, input int i);
      int l;
      if (v.never_m[i] || v.stale_m[i]) return TB_TO;
      l = int'(v.lat[i]) + 1;
      return (l > TB_TO) ? TB_TO : l;
   endfunction

   // Harness models: observe startTests just after each rising edge.
   int hcnt[NT];
   initial begin
      hs.testDone = '0;
      for (int i = 0; i < NT; i++) hcnt[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NT; i++) begin
            if (cfg_stale[i]) begin
               hs.testDone[i] = 1'b1;
            end else if (hs.startTests[i] && !cfg_never[i]) begin
               if (hcnt[i] == int'(cfg_lat[i])) hs.testDone[i] = 1'b1;
               hcnt[i]++;
            end else begin
               hs.testDone[i] = 1'b0;
               hcnt[i] = 0;
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_startTests"},  32'(hs.startTests), 32'h0);
      chk({tag, "_passMask"},    32'(passMask),      32'h0);
      chk({tag, "_timeoutMask"}, 32'(timeoutMask),   32'h0);
      chk({tag, "_currentTest"}, 32'(currentTest),   32'h0);
      chk({tag, "_busy"},        32'(busy),          32'h0);
      chk({tag, "_done"},        32'(done),          32'h0);
      chk({tag, "_allPassed"},   32'(allPassed),     32'h0);
   endtask

   task automatic run_vec(input vec_t v);
      vec_t   e;
      int     cyc, oh_err, busy_err;
      int     hi[NT];
      logic   got, glitched;
      logic [NT-1:0] first_st;

      cfg_lat = v.lat; cfg_never = v.never_m; cfg_stale = v.stale_m;
      hs.dutPassed = v.verdict;
      repeat (3) @(negedge clk);
      sb_q.push_back(v);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; got = 1'b0; glitched = 1'b0; oh_err = 0; busy_err = 0; first_st = '0;
      for (int i = 0; i < NT; i++) hi[i] = 0;
      while (!got && cyc < 200) begin
         if (busy !== 1'b1) busy_err++;
         if (hs.startTests !== '0) begin
            if (first_st == '0) first_st = hs.startTests;
            if (hs.startTests !== (NT'(1) << currentTest)) oh_err++;
         end
         for (int i = 0; i < NT; i++) if (hs.startTests[i] === 1'b1) hi[i]++;
         if (v.glitch && !glitched && hs.startTests[1] === 1'b1) begin
            start = 1'b1; glitched = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            got = 1'b1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;

      chk({v.name, "_done_seen"}, 32'(got), 32'h1);
      if (got && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.name, "_done_cycle"},  32'(cyc),         32'(e.exp_cyc));
         chk({e.name, "_passMask"},    32'(passMask),    32'(e.exp_pass));
         chk({e.name, "_timeoutMask"}, 32'(timeoutMask), 32'(e.exp_to));
         chk({e.name, "_allPassed"},   32'(allPassed),   32'(e.exp_all));
         chk({e.name, "_first_start"}, 32'(first_st),    32'h1);
         chk({e.name, "_onehot_err"},  32'(oh_err),      32'h0);
         chk({e.name, "_busy_err"},    32'(busy_err),    32'h0);
         for (int i = 0; i < NT; i++)
            chk($sformatf("%s_start%0d_len", e.name, i), 32'(hi[i]), 32'(exp_len(e, i)));
         @(negedge clk);
         chk({e.name, "_done_fall"},   32'(done),        32'h0);
         chk({e.name, "_busy_fall"},   32'(busy),        32'h0);
         chk({e.name, "_pass_hold"},   32'(passMask),    32'(e.exp_pass));
         chk({e.name, "_all_hold"},    32'(allPassed),   32'(e.exp_all));
      end else begin
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      vecs[0] = mk("all_pass",   16'h5555, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b1, 33);
      vecs[1] = mk("one_fail",   16'h5555, 4'b1011, 4'b0000, 4'b0000, 1'b0, 4'b1011, 4'b0000, 1'b0, 33);
      vecs[2] = mk("timeout1",   16'h5555, 4'b1111, 4'b0010, 4'b0000, 1'b0, 4'b1101, 4'b0010, 1'b0, 35);
      vecs[3] = mk("stale0",     16'h5555, 4'b1111, 4'b0000, 4'b0001, 1'b0, 4'b1110, 4'b0001, 1'b0, 35);
      vecs[4] = mk("collide_p",  16'h7555, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1, 35);
      vecs[5] = mk("collide_f",  16'h7555, 4'b0111, 4'b0000, 4'b0000, 1'b0, 4'b0111, 4'b0000, 1'b0, 35);

      reset = 1'b1; start = 1'b0; hs.dutPassed = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 6; k++) run_vec(vecs[k]);

      // Reset while harness 2 is in WAIT, then a full clean run.
      cfg_lat = 16'h5555; cfg_never = '0; cfg_stale = '0; hs.dutPassed = 4'b1111;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         if (hs.startTests[2] === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      chk("midrun_reached_h2", 32'(seen), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_outputs("midrun");
      repeat (3) @(negedge clk);
      chk("midrun_idle_busy",  32'(busy),           32'h0);
      chk("midrun_idle_start", 32'(hs.startTests),  32'h0);
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
